qdense_seq: RTL and testbench

Time-multiplexed successor to the combinational quantized dense layer. It computes y[yn] = b[yn] + Σ x[xn]·k[xn][yn] for all YD outputs, but consumes the input vector as a stream of P-element beats over valid/ready. It accumulates into registered per-output accumulators and emits one registered output vector per input vector, with optional ReLU. It sits between an upstream activation stream and the next layer, trading throughput for P·YD multipliers instead of XD·YD.

---
 rtl/qdense_seq_pkg.sv | 23 ++
 rtl/qdense_seq_add.sv | 20 ++
 rtl/qdense_seq.sv | 133 +++++++++++++
 tb/tb_qdense_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/qdense_seq_pkg.sv
// qdense_seq shared types and helpers.
// Holds the FSM state encoding and the elaboration-time size helpers.
package qdense_seq_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  function automatic int cdiv(
    input int a,
    input int d
  );
    return (a + d - 1) / d;
  endfunction

  function automatic int clog2_min1(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qdense_seq_add.sv
// Signed N-input adder used as the per-output term reduction.
// Each BI-bit input is sign-extended to BO bits before summing.
module add #(
  parameter int N  = 2,
  parameter int BI = 8,
  parameter int BO = BI + $clog2(N + 1)
) (
  input  logic [N-1:0][BI-1:0] a,
  output logic [BO-1:0]        s
);

  // sign-extend every operand and reduce
  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + BO'($signed(a[i]));
    end
  end

endmodule

// File: rtl/qdense_seq.sv
// Time-multiplexed quantized dense layer: y = b + x*k, P inputs per beat.
// Accumulates over BEATS handshakes, then presents one registered vector.
module qdense_seq
  import qdense_seq_pkg::*;
#(
  parameter int YD = 8,
  parameter int XD = 8,
  parameter int XB = 8,
  parameter int KB = 8,
  parameter int P  = 2,
  localparam int MB    = XB + KB,
  localparam int YB    = MB + $clog2(XD + 1),
  localparam int BEATS = cdiv(XD, P),
  localparam int CB    = clog2_min1(BEATS)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [XD-1:0][YD-1:0][KB-1:0] k,
  input  logic [YD-1:0][KB-1:0]       b,
  input  logic                        cfg_relu,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [P-1:0][XB-1:0]        s_x,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [YD-1:0][YB-1:0]       m_y
);

  state_t                         state;
  logic [CB-1:0]                  cnt;
  logic [YD-1:0][YB-1:0]          acc;

  logic                           beat0;
  logic                           last;
  logic [BEATS*P-1:0][YD-1:0][KB-1:0] kp;
  logic [P-1:0][YD-1:0][KB-1:0]   ksel;
  logic [YD-1:0][P:0][MB-1:0]     ain;
  logic [YD-1:0][YB-1:0]          tsum;
  logic [YD-1:0][YB-1:0]          nxt;
  logic [YD-1:0][YB-1:0]          yo;

  assign s_ready = (state == ACC);
  assign beat0   = (cnt == '0);
  assign last    = (cnt == CB'(BEATS - 1));

  // zero-pad weights so the last beat's spare lanes multiply by 0
  always_comb begin
    kp = '0;
    for (int r = 0; r < XD; r++) begin
      kp[r] = k[r];
    end
  end

  // select the weight rows belonging to the current beat
  always_comb begin
    ksel = '0;
    for (int bb = 0; bb < BEATS; bb++) begin
      if (cnt == CB'(bb)) begin
        for (int p = 0; p < P; p++) begin
          ksel[p] = kp[bb*P + p];
        end
      end
    end
  end

  // lane products plus bias lane (bias only on beat 0)
  always_comb begin
    ain = '0;
    for (int yn = 0; yn < YD; yn++) begin
      for (int p = 0; p < P; p++) begin
        ain[yn][p] = MB'($signed(s_x[p]))
                   * MB'($signed(ksel[p][yn]));
      end
      ain[yn][P] = beat0 ? MB'($signed(b[yn])) : '0;
    end
  end

  for (genvar yn = 0; yn < YD; yn++) begin : g_add
    add #(
      .N (P + 1),
      .BI(MB),
      .BO(YB)
    ) u_add (
      .a(ain[yn]),
      .s(tsum[yn])
    );
  end

  // fold the running accumulator in and apply optional ReLU
  always_comb begin
    nxt = '0;
    yo  = '0;
    for (int yn = 0; yn < YD; yn++) begin
      nxt[yn] = beat0 ? tsum[yn] : tsum[yn] + acc[yn];
      yo[yn]  = (cfg_relu && nxt[yn][YB-1]) ? '0 : nxt[yn];
    end
  end

  // beat counting, accumulation and output handshake FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ACC;
      cnt     <= '0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_y     <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (s_valid) begin
            acc <= nxt;
            if (last) begin
              m_y     <= yo;
              m_valid <= 1'b1;
              cnt     <= '0;
              state   <= OUT;
            end else begin
              cnt <= cnt + CB'(1);
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_qdense_seq.sv
// Directed bench for qdense_seq with YD=2, XD=3, P=2 (two beats/vector).
// Expected values are hand-computed or from a small integer model.
module tb_qdense_seq;

  localparam int YD = 2;
  localparam int XD = 3;
  localparam int XB = 8;
  localparam int KB = 8;
  localparam int P  = 2;
  localparam int YB = 18;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic [XD-1:0][YD-1:0][KB-1:0] k;
  logic [YD-1:0][KB-1:0]         b;
  logic                          cfg_relu;
  logic                          s_valid;
  logic                          s_ready;
  logic [P-1:0][XB-1:0]          s_x;
  logic                          m_valid;
  logic                          m_ready;
  logic [YD-1:0][YB-1:0]         m_y;

  int checks = 0;
  int errors = 0;
  int xv[3];

  qdense_seq #(
    .YD(YD),
    .XD(XD),
    .XB(XB),
    .KB(KB),
    .P (P)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .k       (k),
    .b       (b),
    .cfg_relu(cfg_relu),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x     (s_x),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_y     (m_y)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_k(input int v);
    for (int i = 0; i < XD; i++)
      for (int j = 0; j < YD; j++)
        k[i][j] = 8'(v);
  endtask

  task automatic beat(input int x0, input int x1);
    int n;
    n = 0;
    s_x[0]  = 8'(x0);
    s_x[1]  = 8'(x1);
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic vec(input int x0, input int x1, input int x2);
    beat(x0, x1);
    chk("mid_valid", m_valid, 0);
    beat(x2, 99);
  endtask

  task automatic expect_y(input string tag, input int e0, input int e1);
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_y0"}, $signed(m_y[0]), e0);
    chk({tag, "_y1"}, $signed(m_y[1]), e1);
    @(negedge clk);
    chk({tag, "_pulse"}, m_valid, 0);
  endtask

  function automatic int model(input int j);
    int s;
    s = int'($signed(b[j]));
    for (int i = 0; i < XD; i++)
      s += xv[i] * int'($signed(k[i][j]));
    if (cfg_relu && s < 0) s = 0;
    return s;
  endfunction

  initial begin
    rstn     = 1'b0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    cfg_relu = 1'b0;
    s_x      = '0;
    k        = '0;
    b        = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_y0", $signed(m_y[0]), 0);
    chk("rst_y1", $signed(m_y[1]), 0);
    chk("rst_ready", s_ready, 1);
    rstn = 1'b1;
    @(negedge clk);

    set_k(1);
    b[0] = 8'(0);
    b[1] = 8'(5);
    vec(1, 2, 3);
    expect_y("ones", 6, 11);

    set_k(-128);
    b[0] = 8'(-128);
    b[1] = 8'(-128);
    vec(-128, -128, -128);
    expect_y("maxneg", 49024, 49024);

    set_k(-2);
    b[0] = 8'(1);
    b[1] = 8'(-1);
    vec(1, 1, 1);
    expect_y("norelu", -5, -7);
    cfg_relu = 1'b1;
    vec(1, 1, 1);
    expect_y("relu", 0, 0);
    cfg_relu = 1'b0;

    set_k(1);
    b[0] = 8'(0);
    b[1] = 8'(5);
    m_ready = 1'b0;
    vec(1, 2, 3);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_ready", s_ready, 0);
      chk("hold_y0", $signed(m_y[0]), 6);
      chk("hold_y1", $signed(m_y[1]), 11);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", s_ready, 1);
    vec(4, 0, 1);
    expect_y("after_hold", 5, 10);

    set_k(3);
    beat(10, 10);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_y0", $signed(m_y[0]), 0);
    chk("midrst_y1", $signed(m_y[1]), 0);
    chk("midrst_ready", s_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    vec(1, 2, 3);
    expect_y("post_rst", 18, 23);

    for (int v = 0; v < 100; v++) begin
      for (int i = 0; i < XD; i++)
        for (int j = 0; j < YD; j++)
          k[i][j] = 8'($urandom_range(0, 255));
      for (int j = 0; j < YD; j++)
        b[j] = 8'($urandom_range(0, 255));
      cfg_relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < XD; i++)
        xv[i] = int'($urandom_range(0, 255)) - 128;
      s_valid = 1'b1;
      s_x[0]  = 8'(xv[0]);
      s_x[1]  = 8'(xv[1]);
      @(negedge clk);
      chk("rnd_b0_valid", m_valid, 0);
      s_x[0] = 8'(xv[2]);
      s_x[1] = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk("rnd_valid", m_valid, 1);
      chk("rnd_y0", $signed(m_y[0]), model(0));
      chk("rnd_y1", $signed(m_y[1]), model(1));
      s_x[0] = 8'($urandom_range(0, 255));
      s_x[1] = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk("rnd_bubble", m_valid, 0);
    end
    s_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
